// File: rtl/img_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// img_loader_pkg
// Shared types and defaults for the image stream loader.
//   - loader_state_e : FSM states of the loader
//   - DEF_*          : default parameter values
//   - addr_w_of()    : address width needed to index a frame of `size` pixels
// ---------------------------------------------------------------------------
package img_loader_pkg;

  function automatic int addr_w_of(input int size);
    // A one-pixel frame still needs a 1-bit address bus.
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_SIZE          = 1024;
  localparam int DEF_ADDR_W        = addr_w_of(DEF_SIZE);
  localparam int DEF_KERNEL_CYCLES = 40000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    KICK,
    RUN,
    DONE
  } loader_state_e;

endpackage

// File: rtl/img_stream_loader_if.sv
// ---------------------------------------------------------------------------
// img_stream_loader_if
// Bundles the pixel stream, the image-memory write port and the kernel
// control/status strobes of the loader.
//   slave  : the loader side (sinks the stream, drives memory and status)
//   master : the environment side (sources the stream, observes the rest)
// ---------------------------------------------------------------------------
interface img_stream_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              in_ready;
  logic              img_p0_addr_en;
  logic [ADDR_W-1:0] img_p0_addr_data;
  logic              img_p0_wr_en;
  logic [WIDTH-1:0]  img_p0_wr_data;
  logic              t;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, img_p0_addr_en, img_p0_addr_data, img_p0_wr_en,
           img_p0_wr_data, t, busy, frame_done, frame_err
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, img_p0_addr_en, img_p0_addr_data, img_p0_wr_en,
           img_p0_wr_data, t, busy, frame_done, frame_err
  );
endinterface

// File: rtl/img_stream_loader_down_counter.sv
// ---------------------------------------------------------------------------
// loader_down_counter
// Loadable down-counter with a zero flag; times the kernel run.
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one; saturates at zero
//   o_zero      : count is zero
// ---------------------------------------------------------------------------
module loader_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/img_stream_loader.sv
// ---------------------------------------------------------------------------
// img_stream_loader
// Loads one image frame from a valid/ready pixel stream into image memory,
// pulses the kernel start strobe once the last write has been presented,
// waits KERNEL_CYCLES and then reports frame completion.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of img_stream_loader_if
//               stream  in_valid/in_data/in_last -> in_ready
//               memory  img_p0_addr_en/addr_data/wr_en/wr_data
//               status  t (kernel start), busy, frame_done, frame_err
// ---------------------------------------------------------------------------
module img_stream_loader
  import img_loader_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SIZE          = DEF_SIZE,
  parameter int ADDR_W        = addr_w_of(SIZE),
  parameter int KERNEL_CYCLES = DEF_KERNEL_CYCLES
) (
  input logic                clk,
  input logic                rst,
  img_stream_loader_if.slave bus
);
  localparam int PCW   = ADDR_W + 1;
  localparam int CNT_W = $clog2(KERNEL_CYCLES) + 1;

  localparam logic [PCW-1:0]   LAST_IDX = PCW'(SIZE - 1);
  localparam logic [PCW-1:0]   PIX_ONE  = PCW'(1);
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(KERNEL_CYCLES - 1);

  loader_state_e     r_state, w_state_next;
  logic [PCW-1:0]    r_pix_cnt, w_pix_cnt_next;
  logic              r_frame_err, w_err_next;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wr_data;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  // in_ready is a decode of the state register, so it is stable for the
  // whole cycle and changes only on a clock edge.
  assign w_in_ready = (r_state == IDLE) || (r_state == LOAD);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pix_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pix_cnt   <= w_pix_cnt_next;
      r_frame_err <= w_err_next;
      r_wr_en     <= w_accept;
      // Address/data hold their last value when nothing is accepted.
      if (w_accept) begin
        r_addr    <= r_pix_cnt[ADDR_W-1:0];
        r_wr_data <= bus.in_data;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pix_cnt_next = r_pix_cnt;
    w_err_next     = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      // IDLE always holds a zero count, so it shares LOAD's accept logic;
      // this also covers a one-pixel frame finishing straight from IDLE.
      IDLE, LOAD: begin
        if (w_accept) begin
          if (r_pix_cnt == LAST_IDX) begin
            w_state_next   = START;
            w_pix_cnt_next = '0;
            w_err_next     = !bus.in_last;   // missing last: keep going
          end else if (bus.in_last) begin
            w_state_next   = IDLE;           // early last: drop the frame
            w_pix_cnt_next = '0;
            w_err_next     = 1'b1;
          end else begin
            w_state_next   = LOAD;
            w_pix_cnt_next = r_pix_cnt + PIX_ONE;
          end
        end
      end
      START: w_state_next = KICK;
      KICK: begin
        w_cnt_load   = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        if (w_cnt_zero) begin
          w_state_next = DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  loader_down_counter #(
    .W (CNT_W)
  ) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (RUN_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign bus.in_ready         = w_in_ready;
  assign bus.img_p0_addr_en   = r_wr_en;
  assign bus.img_p0_addr_data = r_addr;
  assign bus.img_p0_wr_en     = r_wr_en;
  assign bus.img_p0_wr_data   = r_wr_data;
  assign bus.t                = (r_state == KICK);
  assign bus.busy             = (r_state != IDLE);
  assign bus.frame_done       = (r_state == DONE);
  assign bus.frame_err        = r_frame_err;
endmodule

// File: tb/tb_img_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_img_stream_loader
// Self-checking bench for img_stream_loader with SIZE = 16, KERNEL_CYCLES = 8.
// Expected writes are queued as pixels are accepted and popped as the memory
// port presents them; pulse timing is checked per scenario.
// ---------------------------------------------------------------------------
module tb_img_stream_loader;
  localparam int WIDTH = 32;
  localparam int SIZE  = 16;
  localparam int AW    = 4;
  localparam int KC    = 8;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  wr_t exp_q[$];
  wr_t mon_e;
  int  exp_idx = 0;
  int  acc_cyc = 0;

  int wr_cnt = 0, last_wr_cyc = -1;
  int t_cnt = 0, t_cyc = -1;
  int done_cnt = 0, done_cyc = -1;
  int err_cnt = 0, err_cyc = -1;

  img_stream_loader_if #(.WIDTH(WIDTH), .ADDR_W(AW)) bus ();

  img_stream_loader #(
    .WIDTH         (WIDTH),
    .SIZE          (SIZE),
    .ADDR_W        (AW),
    .KERNEL_CYCLES (KC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every write strobe, records pulses.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.img_p0_addr_en !== bus.img_p0_wr_en) begin
        errors++;
        $display("FAIL addr_en_eq_wr_en cyc %0d got %b want %b", cyc, bus.img_p0_addr_en, bus.img_p0_wr_en);
      end
    end
    if (bus.img_p0_wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc %0d got addr %0d data %h want no write", cyc, bus.img_p0_addr_data, bus.img_p0_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.img_p0_addr_data !== mon_e.addr || bus.img_p0_wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL write cyc %0d got addr %0d data %h want addr %0d data %h", cyc, bus.img_p0_addr_data, bus.img_p0_wr_data, mon_e.addr, mon_e.data);
        end else begin
          $display("write cyc %0d addr %0d data %h", cyc, mon_e.addr, mon_e.data);
        end
      end
    end
    if (bus.t === 1'b1) begin t_cnt++; t_cyc = cyc; end
    if (bus.frame_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic clear_obs();
    wr_cnt = 0; t_cnt = 0; done_cnt = 0; err_cnt = 0;
    last_wr_cyc = -1; t_cyc = -1; done_cyc = -1; err_cyc = -1;
  endtask

  // Leaves in_valid high; caller decides when to drop it.
  task automatic send_pixel(input logic [WIDTH-1:0] d, input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready %b want 1", bus.in_ready);
    end else begin
      @(posedge clk);
      exp_q.push_back('{addr: AW'(exp_idx), data: d});
      if (exp_idx == SIZE - 1) exp_idx = 0;
      else if (last) exp_idx = 0;
      else exp_idx++;
      #1;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout got no frame_done want one within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    #1;
    checks++;
    if ({bus.img_p0_wr_en, bus.img_p0_addr_en, bus.t, bus.busy, bus.frame_done, bus.frame_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000000", {bus.img_p0_wr_en, bus.img_p0_addr_en, bus.t, bus.busy, bus.frame_done, bus.frame_err});
    end
    checks++;
    if (bus.img_p0_addr_data !== '0 || bus.img_p0_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %h want 0 0", bus.img_p0_addr_data, bus.img_p0_wr_data);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int i = 0; i < SIZE; i++) send_pixel(WIDTH'(i), (i == SIZE - 1));
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(40);
    checks++;
    if (wr_cnt !== SIZE || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_writes got %0d pending %0d want %0d pending 0", wr_cnt, exp_q.size(), SIZE);
    end
    checks++;
    if (t_cnt !== 1 || t_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL b2b_t got count %0d cyc %0d want count 1 cyc %0d", t_cnt, t_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== t_cyc + KC + 1) begin
      errors++;
      $display("FAIL b2b_done got count %0d cyc %0d want count 1 cyc %0d", done_cnt, done_cyc, t_cyc + KC + 1);
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_err got %0d want 0", err_cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got in_ready %b busy %b want 1 0", bus.in_ready, bus.busy);
    end
    $display("test_back_to_back done t_cyc %0d done_cyc %0d", t_cyc, done_cyc);
  endtask

  task automatic test_gappy();
    clear_obs();
    for (int i = 0; i < SIZE; i++) begin
      send_pixel(32'h100 + WIDTH'(i * 3), (i == SIZE - 1));
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      if (i != SIZE - 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    wait_done(40);
    checks++;
    if (wr_cnt !== SIZE || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL gappy_writes got %0d pending %0d want %0d pending 0", wr_cnt, exp_q.size(), SIZE);
    end
    checks++;
    if (t_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL gappy_pulses got t %0d done %0d err %0d want 1 1 0", t_cnt, done_cnt, err_cnt);
    end
    $display("test_gappy done");
  endtask

  task automatic test_early_last();
    clear_obs();
    for (int i = 0; i < 6; i++) send_pixel(32'hE000 + WIDTH'(i), (i == 5));
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 1 || err_cyc !== acc_cyc) begin
      errors++;
      $display("FAIL early_err got count %0d cyc %0d want count 1 cyc %0d", err_cnt, err_cyc, acc_cyc);
    end
    checks++;
    if (wr_cnt !== 6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL early_writes got %0d pending %0d want 6 pending 0", wr_cnt, exp_q.size());
    end
    checks++;
    if (t_cnt !== 0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_state got t %0d busy %b in_ready %b want 0 0 1", t_cnt, bus.busy, bus.in_ready);
    end
    $display("test_early_last done err_cyc %0d", err_cyc);
  endtask

  task automatic test_missing_last();
    clear_obs();
    for (int i = 0; i < SIZE; i++) send_pixel(32'hB000 + WIDTH'(i), 1'b0);
    bus.in_valid = 1'b0;
    begin
      int last_acc = acc_cyc;
      wait_done(40);
      checks++;
      if (err_cnt !== 1 || err_cyc !== last_acc) begin
        errors++;
        $display("FAIL missing_err got count %0d cyc %0d want count 1 cyc %0d", err_cnt, err_cyc, last_acc);
      end
    end
    checks++;
    if (t_cnt !== 1 || done_cnt !== 1 || wr_cnt !== SIZE || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_frame got t %0d done %0d writes %0d pending %0d want 1 1 %0d 0", t_cnt, done_cnt, wr_cnt, exp_q.size(), SIZE);
    end
    $display("test_missing_last done");
  endtask

  task automatic test_valid_during_run();
    int rdy_hi = 0;
    clear_obs();
    for (int i = 0; i < SIZE; i++) send_pixel(32'h2000 + WIDTH'(i), (i == SIZE - 1));
    bus.in_data = 32'hA5A5_0000; bus.in_last = 1'b0;   // in_valid stays high
    // START, KICK, KC x RUN, DONE
    for (int k = 0; k < KC + 3; k++) begin
      if (bus.in_ready === 1'b1) rdy_hi++;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy_hi !== 0) begin
      errors++;
      $display("FAIL run_in_ready got %0d ready cycles want 0", rdy_hi);
    end
    checks++;
    if (t_cnt !== 1 || done_cnt !== 1 || wr_cnt !== SIZE) begin
      errors++;
      $display("FAIL run_pulses got t %0d done %0d writes %0d want 1 1 %0d", t_cnt, done_cnt, wr_cnt, SIZE);
    end
    send_pixel(32'hA5A5_0000, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (wr_cnt !== SIZE + 1 || exp_q.size() !== 0 || bus.img_p0_addr_data !== AW'(0)) begin
      errors++;
      $display("FAIL run_first_accept got writes %0d pending %0d addr %0d want %0d 0 0", wr_cnt, exp_q.size(), bus.img_p0_addr_data, SIZE + 1);
    end
    $display("test_valid_during_run done");
  endtask

  // Continues the frame started at the end of test_valid_during_run.
  task automatic test_reset_mid_load();
    for (int i = 1; i < 7; i++) send_pixel(32'h3000 + WIDTH'(i), 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL mid_load_pre got busy %b pending %0d want 1 0", bus.busy, exp_q.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.img_p0_wr_en, bus.img_p0_addr_en, bus.t, bus.busy, bus.frame_done, bus.frame_err} !== 6'b0
        || bus.img_p0_addr_data !== '0 || bus.img_p0_wr_data !== '0) begin
      errors++;
      $display("FAIL mid_load_async got strobes %b addr %h data %h want 000000 0 0",
               {bus.img_p0_wr_en, bus.img_p0_addr_en, bus.t, bus.busy, bus.frame_done, bus.frame_err},
               bus.img_p0_addr_data, bus.img_p0_wr_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_idx = 0;
    clear_obs();
    for (int i = 0; i < SIZE; i++) send_pixel(32'h4000 + WIDTH'(i), (i == SIZE - 1));
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(40);
    checks++;
    if (t_cnt !== 1 || wr_cnt !== SIZE || exp_q.size() !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL mid_load_reload got t %0d writes %0d pending %0d err %0d want 1 %0d 0 0", t_cnt, wr_cnt, exp_q.size(), err_cnt, SIZE);
    end
    $display("test_reset_mid_load done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gappy();
    test_early_last();
    test_missing_last();
    test_valid_during_run();
    test_reset_mid_load();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
- Upstream feeder for the unsharp_mask kernel (HIR and HLS variants).
- Accepts one image frame as a valid/ready pixel stream and writes it into the image memory through a single memref-style write port.
- Issues the kernel start pulse once the frame is fully committed, then holds off new input for a fixed kernel run time.
- Signals frame completion, so frames can be processed back-to-back without a testbench sequencer.

Parameters:
- WIDTH, 32: pixel data width.
- SIZE, 1024: pixels per frame, which is also the image memory depth.
- ADDR_W, 10: address width; must equal clog2(SIZE).
- KERNEL_CYCLES, 40000: cycles to wait after the start pulse before the frame counts as done; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel stream valid.
- in_data  in  WIDTH  pixel value.
- in_last  in  1  marks the final pixel of a frame.
- in_ready  out  1  loader can accept a pixel.
- img_p0_addr_en  out  1  write address valid; equals img_p0_wr_en.
- img_p0_addr_data  out  ADDR_W  write address.
- img_p0_wr_en  out  1  write strobe.
- img_p0_wr_data  out  WIDTH  write data.
- t  out  1  kernel start pulse, one cycle wide.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of kernel run.
- frame_err  out  1  one-cycle pulse on an in_last framing error.

Behaviour:
- Reset: one clock, asynchronous active-high reset. While rst is high:
  - state = IDLE; pixel counter and cycle counter = 0.
  - All outputs = 0, except in_ready = 1 once the block is in IDLE after reset.
- Handshake:
  - A pixel is accepted on a rising edge where in_valid and in_ready are both high.
  - in_ready is a registered output: 1 in IDLE and LOAD, 0 in every other state.
- Write path (registered, 1-cycle latency):
  - A pixel accepted at edge k drives wr_en = addr_en = 1 during cycle k+1.
  - In that cycle, addr_data = pixel index (0..SIZE-1) and wr_data = the accepted in_data.
  - With no accept at edge k, wr_en = 0 in cycle k+1; addr and data hold their last values.
- States:
  - IDLE: the first accept writes address 0 and moves to LOAD (counter = 1). If that pixel also has in_last and SIZE > 1, this is an early-last error.
  - LOAD:
    - Each accept increments the counter.
    - Gaps in in_valid are allowed and leave the state unchanged.
    - On accepting pixel SIZE-1, go to START and drop in_ready on the next cycle.
  - START:
    - Lasts exactly one cycle, the cycle in which the final write strobe is presented.
    - Then go to KICK.
  - KICK:
    - t = 1 for exactly one cycle, the cycle after the final wr_en, so memory is committed before the kernel starts.
    - Load the cycle counter with KERNEL_CYCLES-1.
    - Then go to RUN.
  - RUN:
    - Decrement the cycle counter each cycle.
    - When it reaches 0, go to DONE.
    - in_valid is ignored.
  - DONE: frame_done = 1 for one cycle, then go to IDLE with in_ready = 1 on the following cycle.
- Framing errors:
  - Early last: in_last accepted on a pixel with index < SIZE-1.
    - frame_err pulses in the cycle after the accept; that pixel's write still occurs.
    - Return to IDLE with the counter cleared; no t pulse.
    - The next accepted pixel writes address 0.
  - Missing last: pixel SIZE-1 accepted with in_last = 0.
    - frame_err pulses in the cycle after the accept.
    - The frame still proceeds to START, KICK, RUN and DONE normally.
- Reset mid-operation: all state is abandoned immediately; partially written memory is not cleared; no t or frame_done pulse is issued.
- Widths:
  - The pixel counter is ADDR_W+1 bits, so SIZE-1 compares without wrap.
  - The cycle counter is clog2(KERNEL_CYCLES)+1 bits.
  - Addresses never exceed SIZE-1.
- Data is passed through unmodified; no arithmetic on pixel values.

Decomposition:
- Shared package img_loader_pkg:
  - loader_state_e enum: IDLE, LOAD, START, KICK, RUN, DONE.
  - Default-parameter localparams.
  - ADDR_W derivation helper.
- One sub-module, loader_down_counter: loadable down-counter with a zero flag, used for the RUN wait.
- The FSM and write path stay in the top module.

Test Plan (all with SIZE = 16, KERNEL_CYCLES = 8):
- Back-to-back frame: 16 pixels 0..15 with in_last on the 16th -> writes to addr 0..15 carrying data 0..15; t = 1 exactly one cycle after the addr-15 wr_en; frame_done 9 cycles after t; frame_err never asserts.
- Gappy stream: in_valid toggles 1,0,0,1,... -> same 16 writes in order; wr_en is low in every gap cycle; one t pulse.
- Early last: in_last on pixel 5 -> frame_err pulses once; addr 5 is written; no t; the next frame's first pixel writes addr 0.
- Missing last: 16 pixels with in_last = 0 -> frame_err pulses the cycle after the 16th accept; t and frame_done still occur.
- Valid during RUN: hold in_valid = 1 from KICK through DONE -> in_ready = 0, no wr_en; the first accept after DONE writes addr 0.
- Reset mid-LOAD: assert rst after 7 pixels -> all outputs 0 within the same cycle (asynchronous); after release a full 16-pixel frame loads from addr 0 and produces one t.
